// File: rtl/haui_gpio_pkg.sv
// Shared constants for the haui Wishbone GPIO stage: register word offsets,
// address window mask and handshake FSM states.
package haui_gpio_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 32;

  // Window is 64 bytes; upper address bits must match the base exactly.
  localparam logic [WB_AW-1:0] WB_WINDOW = 32'hFFFF_FFC0;

  // Word index (adr[5:2]) of each register.
  localparam logic [3:0] OFF_DOUT    = 4'h0;
  localparam logic [3:0] OFF_OE      = 4'h1;
  localparam logic [3:0] OFF_DIN     = 4'h2;
  localparam logic [3:0] OFF_RISE_EN = 4'h3;
  localparam logic [3:0] OFF_FALL_EN = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h5;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_e;

  // Expand the four byte selects into a 32-bit lane mask.
  function automatic logic [WB_DW-1:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/haui_wb_gpio_if.sv
// Wishbone classic slave bus as seen by the GPIO stage.
interface haui_wb_gpio_if;
  import haui_gpio_pkg::*;

  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [WB_AW-1:0] wbs_adr_i;
  logic [WB_DW-1:0] wbs_dat_i;
  logic             wbs_ack_o;
  logic [WB_DW-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/haui_sync2.sv
// Parameterised two-flop synchroniser for asynchronous pad inputs.
module haui_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/haui_wb_gpio.sv
// Wishbone slave GPIO block: output data / enable, synchronised inputs and
// per-pin edge interrupts collected into irq[0].
module haui_wb_gpio
  import haui_gpio_pkg::*;
#(
  parameter int unsigned      NPINS     = 16,
  parameter logic [WB_AW-1:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  haui_wb_gpio_if.slave    wb,
  input  logic [NPINS-1:0] io_in,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic [2:0]       irq
);

  wb_state_e        r_state;
  logic             r_ack;
  logic [WB_DW-1:0] r_dat;
  logic [NPINS-1:0] r_dout;
  logic [NPINS-1:0] r_oe;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_status;
  logic [NPINS-1:0] r_hist;
  logic             r_irq;

  logic [NPINS-1:0] w_sync;
  logic             w_hit;
  logic             w_wr;
  logic [3:0]       w_idx;
  logic [WB_DW-1:0] w_bmask;
  logic [WB_DW-1:0] w_rdata;
  logic [NPINS-1:0] w_set;
  logic [NPINS-1:0] w_clr;

  haui_sync2 #(.WIDTH(NPINS)) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_d     (io_in),
    .o_q     (w_sync)
  );

  assign w_hit   = wb.wbs_cyc_i && wb.wbs_stb_i &&
                   ((wb.wbs_adr_i & WB_WINDOW) == BASE_ADDR);
  assign w_idx   = wb.wbs_adr_i[5:2];
  assign w_bmask = sel_to_mask(wb.wbs_sel_i);
  assign w_wr    = (r_state == IDLE) && w_hit && wb.wbs_we_i;

  // Edges are qualified by the enables at detection time; disabled edges vanish.
  assign w_set = (w_sync & ~r_hist & r_rise_en) | (~w_sync & r_hist & r_fall_en);
  assign w_clr = (w_wr && (w_idx == OFF_STATUS)) ? NPINS'(wb.wbs_dat_i & w_bmask) : '0;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      OFF_DOUT:    w_rdata = WB_DW'(r_dout);
      OFF_OE:      w_rdata = WB_DW'(r_oe);
      OFF_DIN:     w_rdata = WB_DW'(w_sync);
      OFF_RISE_EN: w_rdata = WB_DW'(r_rise_en);
      OFF_FALL_EN: w_rdata = WB_DW'(r_fall_en);
      OFF_STATUS:  w_rdata = WB_DW'(r_status);
      default:     w_rdata = '0;
    endcase
  end

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [NPINS-1:0] merge(input logic [NPINS-1:0] old_v,
                                             input logic [WB_DW-1:0] new_v,
                                             input logic [WB_DW-1:0] mask);
    return NPINS'((WB_DW'(old_v) & ~mask) | (new_v & mask));
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_dout    <= '0;
      r_oe      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_hist    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_hist   <= w_sync;
      r_status <= (r_status & ~w_clr) | w_set;
      r_irq    <= |r_status;
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_dat <= '0;
          if (w_hit) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (wb.wbs_we_i) begin
              case (w_idx)
                OFF_DOUT:    r_dout    <= merge(r_dout,    wb.wbs_dat_i, w_bmask);
                OFF_OE:      r_oe      <= merge(r_oe,      wb.wbs_dat_i, w_bmask);
                OFF_RISE_EN: r_rise_en <= merge(r_rise_en, wb.wbs_dat_i, w_bmask);
                OFF_FALL_EN: r_fall_en <= merge(r_fall_en, wb.wbs_dat_i, w_bmask);
                default: ;
              endcase
            end else begin
              r_dat <= w_rdata;
            end
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_dat   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_dat   <= '0;
        end
      endcase
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign io_out       = r_dout;
  assign io_oeb       = ~r_oe;
  assign irq          = {2'b00, r_irq};

endmodule

// File: tb/tb_haui_wb_gpio.sv
// Directed self-checking bench for haui_wb_gpio.
module tb_haui_wb_gpio;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic [2:0]  irq;

  int n_tests = 0;
  int n_fail  = 0;

  haui_wb_gpio_if bus ();

  haui_wb_gpio #(.NPINS(16), .BASE_ADDR(BASE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  // One transaction; lat = edges until ack, or -1 when none within 10 cycles.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    bus.wbs_sel_i = sel;
    lat  = -1;
    rdat = 32'hDEAD_BEEF;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o === 1'b1) begin
        lat  = i;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (io_oeb !== 16'hFFFF) begin n_fail++; $display("FAIL reset_oeb got %h exp ffff", io_oeb); end
    n_tests++;
    if (io_out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h exp 0000", io_out); end
    n_tests++;
    if (irq !== 3'b000) begin n_fail++; $display("FAIL reset_irq got %b exp 000", irq); end
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", bus.wbs_ack_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_oe_dout();
    logic [31:0] d;
    int lat;
    wb_xfer(1'b1, BASE + 32'h04, 32'h0000_00FF, 4'hF, d, lat);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL oe_wr_lat got %0d exp 1", lat); end
    wb_xfer(1'b1, BASE + 32'h00, 32'h0000_A5A5, 4'hF, d, lat);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL dout_wr_lat got %0d exp 1", lat); end
    n_tests++;
    if (io_oeb !== 16'hFF00) begin n_fail++; $display("FAIL oeb got %h exp ff00", io_oeb); end
    n_tests++;
    if (io_out !== 16'hA5A5) begin n_fail++; $display("FAIL out got %h exp a5a5", io_out); end
    n_tests++;
    if (bus.wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL dat_idle got %h exp 0", bus.wbs_dat_o); end
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (lat != 1 || d !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL oe_rd got %h lat %0d exp 000000ff lat 1", d, lat);
    end
  endtask

  task automatic test_byte_sel();
    logic [31:0] d;
    int lat;
    wb_xfer(1'b1, BASE + 32'h00, 32'h0, 4'hF, d, lat);
    wb_xfer(1'b1, BASE + 32'h00, 32'h1234_5678, 4'b0010, d, lat);
    wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0000_5600) begin n_fail++; $display("FAIL bytesel_rd got %h exp 00005600", d); end
    n_tests++;
    if (io_out !== 16'h5600) begin n_fail++; $display("FAIL bytesel_out got %h exp 5600", io_out); end
  endtask

  task automatic test_din();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    io_in = 16'h8001;
    repeat (3) @(posedge clk);
    wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0000_8001) begin n_fail++; $display("FAIL din_rd got %h exp 00008001", d); end
    @(negedge clk);
    io_in = 16'h0000;
    repeat (4) @(posedge clk);
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL status_disabled got %h exp 0", d); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    int lat;
    wb_xfer(1'b1, BASE + 32'h0C, 32'h0000_0001, 4'hF, d, lat);
    repeat (2) @(posedge clk);
    @(negedge clk);
    io_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq[0]); end
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 3'b001) begin n_fail++; $display("FAIL irq_set got %b exp 001", irq); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL status_set got %h exp 00000001", d); end
    wb_xfer(1'b1, BASE + 32'h14, 32'h0000_0001, 4'hF, d, lat);
    @(posedge clk);
    #1;
    n_tests++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq[0]); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL status_clear got %h exp 0", d); end
  endtask

  task automatic test_clear_vs_set();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    io_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    io_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = BASE + 32'h14;
    bus.wbs_dat_i = 32'h0000_0001;
    bus.wbs_sel_i = 4'hF;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL clrset_ack got %b exp 1", bus.wbs_ack_o); end
    @(negedge clk);
    bus_idle();
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL clrset_status got %h exp 00000001", d); end
    n_tests++;
    if (irq !== 3'b001) begin n_fail++; $display("FAIL clrset_irq got %b exp 001", irq); end
  endtask

  task automatic test_address();
    logic [31:0] d;
    int lat;
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL hole_rd got %h lat %0d exp 0 lat 1", d, lat); end
    wb_xfer(1'b1, 32'h3100_0000, 32'hFFFF_FFFF, 4'hF, d, lat);
    n_tests++;
    if (lat != -1) begin n_fail++; $display("FAIL foreign_ack got lat %0d exp -1", lat); end
    n_tests++;
    if (io_out !== 16'h5600) begin n_fail++; $display("FAIL foreign_side_effect got %h exp 5600", io_out); end
  endtask

  task automatic test_back_to_back();
    logic exp_pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE + 32'h00;
    bus.wbs_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_tests++;
      if (bus.wbs_ack_o !== exp_pat[k]) begin
        n_fail++; $display("FAIL held_stb_%0d got %b exp %b", k, bus.wbs_ack_o, exp_pat[k]);
      end
    end
    @(negedge clk);
    bus_idle();
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL held_stb_tail got %b exp 0", bus.wbs_ack_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE + 32'h00;
    bus.wbs_sel_i = 4'hF;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got %b exp 0", bus.wbs_ack_o); end
    n_tests++;
    if (io_out !== 16'h0 || io_oeb !== 16'hFFFF || irq !== 3'b0) begin
      n_fail++; $display("FAIL rst_mid_regs got out %h oeb %h irq %b exp 0 ffff 0", io_out, io_oeb, irq);
    end
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    io_in = 16'h0000;
    bus_idle();
    test_reset();
    test_oe_dout();
    test_byte_sel();
    test_din();
    test_edge_irq();
    test_clear_vs_set();
    test_address();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
